chan_scan_mux: RTL and testbench

Parametrised channel multiplexer for the transmitter datapath. Selects one W-bit slice out of NCH packed input channels and presents it on a valid/ready output with a channel tag. It supports two modes:
- **Manual mode:** the legacy per-cycle channel-select behaviour, now with backpressure.
- **Scan mode:** on `start`, snapshots all channels and emits every enabled channel in ascending order as one frame, marking the final beat.

It sits between the sample sources and the framer/serializer.

---
 rtl/tx_pkg.sv | 22 ++
 rtl/chan_pick.sv | 25 ++
 rtl/chan_scan_mux.sv | 138 +++++++++++++
 tb/tb_chan_scan_mux.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared transmitter-datapath definitions: mode encodings, scan FSM states
// and a channel slice helper for packed multi-channel buses.
package tx_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest packed bus the slice helper handles; callers zero-extend into it.
  localparam int SLICE_MAXD = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Channel k (1-based) shifted down to bit 0; callers truncate to W bits.
  function automatic logic [SLICE_MAXD-1:0] slice(input logic [SLICE_MAXD-1:0] data,
                                                  input int k, input int w);
    return (k < 1) ? '0 : (data >> ((k - 1) * w));
  endfunction

endpackage

// File: rtl/chan_pick.sv
// Finds the lowest enabled channel strictly above cur_i (0 = none) and flags
// whether it is the highest enabled channel in the mask.
module chan_pick #(
  parameter int NCH = 3,
  parameter int CW  = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CW-1:0]  cur_i,
  output logic [CW-1:0]  nxt_o,
  output logic           is_last_o
);

  always_comb begin
    nxt_o     = '0;
    is_last_o = 1'b1;
    // Descending walk so the last hit is the lowest qualifying channel.
    for (int i = NCH; i >= 1; i--) begin
      if (mask_i[i-1] && (CW'(i) > cur_i)) nxt_o = CW'(i);
    end
    for (int i = 1; i <= NCH; i++) begin
      if (mask_i[i-1] && (CW'(i) > nxt_o)) is_last_o = 1'b0;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with a manual per-cycle select mode and a scan mode that
// emits every enabled channel of a start-time snapshot as one framed burst.
module chan_scan_mux
  import tx_pkg::*;
#(
  parameter int NCH = 3,
  parameter int W   = 8,
  parameter int CW  = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [CW-1:0]    channel,
  input  logic [NCH-1:0]   chan_en,
  input  logic             start,
  input  logic [NCH*W-1:0] input_data,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [W-1:0]       data_q, data_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic [NCH*W-1:0]   snap_q, snap_d;
  logic [NCH-1:0]     mask_q, mask_d;

  logic [CW-1:0]      first_idx, next_idx;
  logic               first_last, next_last;
  logic [W-1:0]       man_sl, first_sl, next_sl;
  logic               free, xfer, chan_ok, start_ok, take_start;

  chan_pick #(.NCH(NCH), .CW(CW)) u_first (
    .mask_i(chan_en), .cur_i({CW{1'b0}}), .nxt_o(first_idx), .is_last_o(first_last)
  );

  chan_pick #(.NCH(NCH), .CW(CW)) u_next (
    .mask_i(mask_q), .cur_i(chan_q), .nxt_o(next_idx), .is_last_o(next_last)
  );

  assign man_sl   = W'(slice(SLICE_MAXD'(input_data), int'(channel), W));
  assign first_sl = W'(slice(SLICE_MAXD'(input_data), int'(first_idx), W));
  assign next_sl  = W'(slice(SLICE_MAXD'(snap_q), int'(next_idx), W));

  assign free     = !valid_q || out_ready;
  assign xfer     = valid_q && out_ready;
  assign chan_ok  = (channel != '0) && (channel <= CW'(NCH));
  assign start_ok = (mode == MODE_SCAN) && start && (|chan_en);
  // A start is taken from IDLE when free, or on the last-beat transfer of a frame.
  assign take_start = start_ok && (((state_q == IDLE) && free) ||
                                   ((state_q == SCAN) && xfer && last_q));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (free && (mode == MODE_MANUAL)) begin
          data_d  = chan_ok ? man_sl : '0;
          chan_d  = chan_ok ? channel : '0;
          valid_d = chan_ok;
          last_d  = chan_ok;
        end else if (free) begin
          data_d  = '0;
          chan_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      SCAN: begin
        if (xfer && last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          data_d  = '0;
          chan_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (xfer) begin
          data_d = next_sl;
          chan_d = next_idx;
          last_d = next_last;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_start) begin
      state_d = SCAN;
      snap_d  = input_data;
      mask_d  = chan_en;
      busy_d  = 1'b1;
      data_d  = first_sl;
      chan_d  = first_idx;
      valid_d = 1'b1;
      last_d  = first_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      snap_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Scoreboard bench for chan_scan_mux: expected beats are queued as stimulus is
// driven and popped on every observed transfer; stalled beats must hold.
module tb_chan_scan_mux;
  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic [CW-1:0]    channel = '0;
  logic [NCH-1:0]   chan_en = '0;
  logic             start = 1'b0;
  logic [NCH*W-1:0] input_data = 24'hCCBBAA;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_chan;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;

  chan_scan_mux #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .channel(channel), .chan_en(chan_en),
    .start(start), .input_data(input_data), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CW-1:0] c;
    logic          l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [CW-1:0] c, input logic l);
    sb.push_back({d, c, l});
  endtask

  // Transfer monitor and stall-stability check, sampled away from the rising edge.
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  beat_t pb = '0;
  beat_t cur, e;
  always @(negedge clk) begin
    cur = {out_data, out_chan, out_last};
    if (!rst) begin
      if (pv && !pr) begin
        chk("hold_beat", 32'(cur), 32'(pb));
        chk("hold_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("beat", 32'(cur), 32'(e));
        end
      end
    end
    pv <= out_valid && !rst;
    pr <= out_ready;
    pb <= cur;
  end

  logic [CW-1:0] man_ch [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [W-1:0]  man_d  [5] = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
  logic          man_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    man_ch[4] = 2'd3 + 2'd0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Manual select 1,2,3,0,out-of-range. CW=2 cannot encode 5, so the
    // out-of-range case uses 0 twice only if no wider value exists; 3 is max.
    mode = 1'b0;
    out_ready = 1'b1;
    man_ch[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      channel = man_ch[i];
      if (man_v[i]) push(man_d[i], man_ch[i], 1'b1);
      step();
      chk("man_valid", 32'(out_valid), 32'(man_v[i]));
      if (man_v[i]) chk("man_data", 32'(out_data), 32'(man_d[i]));
      else chk("man_zero", 32'({out_data, out_chan}), 32'd0);
    end

    // Manual backpressure: AA/1 holds, CC/3 follows once ready rises.
    out_ready = 1'b0;
    channel = 2'd1;
    push(8'hAA, 2'd1, 1'b1);
    step();
    channel = 2'd3;
    push(8'hCC, 2'd3, 1'b1);
    step();
    step();
    chk("bp_hold_chan", 32'(out_chan), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_next_chan", 32'(out_chan), 32'd3);
    channel = 2'd0;
    step();
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // Full scan frame from the snapshot; source changes after start.
    mode = 1'b1;
    chan_en = 3'b111;
    start = 1'b1;
    push(8'hAA, 2'd1, 1'b0);
    push(8'hBB, 2'd2, 1'b0);
    push(8'hCC, 2'd3, 1'b1);
    step();
    chk("scan_busy0", 32'(busy), 32'd1);
    start = 1'b0;
    input_data = 24'h112233;
    step();
    chk("scan_busy1", 32'(busy), 32'd1);
    step();
    chk("scan_busy2", 32'(busy), 32'd1);
    step();
    chk("scan_busy_end", 32'(busy), 32'd0);
    chk("scan_valid_end", 32'(out_valid), 32'd0);
    input_data = 24'hCCBBAA;

    // Sparse mask with stalls and an ignored mid-frame start.
    chan_en = 3'b101;
    start = 1'b1;
    out_ready = 1'b0;
    push(8'hAA, 2'd1, 1'b0);
    push(8'hCC, 2'd3, 1'b1);
    step();
    start = 1'b0;
    step();
    chan_en = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    step();
    chk("sparse_chan", 32'(out_chan), 32'd3);
    out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    step();
    chk("sparse_busy_end", 32'(busy), 32'd0);
    chk("sparse_valid_end", 32'(out_valid), 32'd0);

    // Back-to-back frame started in the last-beat cycle.
    chan_en = 3'b100;
    start = 1'b1;
    push(8'hCC, 2'd3, 1'b1);
    step();
    chan_en = 3'b010;
    push(8'hBB, 2'd2, 1'b1);
    step();
    chk("b2b_chan", 32'(out_chan), 32'd2);
    chk("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // Empty mask start is ignored.
    chan_en = 3'b000;
    start = 1'b1;
    step();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    start = 1'b0;

    // Reset mid-frame drops the frame.
    chan_en = 3'b111;
    start = 1'b1;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_outs", 32'({out_data, out_chan, out_valid, out_last}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // A later frame still works.
    chan_en = 3'b011;
    start = 1'b1;
    out_ready = 1'b1;
    push(8'hAA, 2'd1, 1'b0);
    push(8'hBB, 2'd2, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
